// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcode map,
// sequencer states and the instruction classes the sequencer branches on.
package cpu_pkg;

    // Five-bit opcodes carried in ir[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // Sequencer states; T0..T7 are instruction steps, WAIT stretches div
    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
        ST_WAIT, ST_PAUSE, ST_HALT
    } state_t;

    // Groups of opcodes that share the same step sequence
    typedef enum logic [3:0] {
        CL_ALU_RR, CL_ALU_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI,
        CL_ST, CL_BR, CL_SINGLE, CL_NOP, CL_HALT
    } iclass_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps an opcode onto the instruction class that selects its step sequence.
// Undefined opcodes fall into CL_NOP so they execute as a harmless no-op.
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    iclass
);

    // Pure lookup; no state
    always_comb begin
        iclass = CL_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL:   iclass = CL_ALU_RR;
            OP_ADDI, OP_ANDI, OP_ORI:         iclass = CL_ALU_IMM;
            OP_NEG, OP_NOT:                   iclass = CL_UNARY;
            OP_MUL, OP_DIV:                   iclass = CL_MULDIV;
            OP_LD:                            iclass = CL_LD;
            OP_LDI:                           iclass = CL_LDI;
            OP_ST:                            iclass = CL_ST;
            OP_BR:                            iclass = CL_BR;
            OP_JR, OP_IN, OP_OUT,
            OP_MFHI, OP_MFLO:                 iclass = CL_SINGLE;
            OP_HALT:                          iclass = CL_HALT;
            default:                          iclass = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the 32-bit bus CPU. Steps through fetch
// (T0-T2) and a class-specific execute sequence, then returns to T0 or
// parks in PAUSE when stop is requested at the instruction boundary.
module control_unit
    import cpu_pkg::*;
#(
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        run,
    output logic [4:0]  alu_op,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic        PCout, PCin, incPC, MARin, MDRin, MDRout, IRin,
    output logic        Yin, Zin, ZLowOut, ZHighOut,
    output logic        HIin, LOin, HIout, LOout, InPortout, OutPortIn, CONN_in,
    output logic        read, write
);

    localparam int CW = $clog2(DIV_CYCLES + 2);
    localparam bit DIV_WAITS = (DIV_CYCLES != 0);

    state_t          state_reg, state_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [4:0]      opcode;
    iclass_t         iclass;
    logic            is_div, last_wait;
    state_t          boundary;
    logic            unused_ir;

    assign opcode    = ir[31:27];
    assign is_div    = (opcode == OP_DIV);
    assign last_wait = (wait_cnt_reg == CW'(1));
    assign boundary  = stop ? ST_PAUSE : ST_T0;
    assign unused_ir = ^ir[26:0];

    instr_class_decode u_decode (
        .opcode (opcode),
        .iclass (iclass)
    );

    // Step sequencing and the div wait counter
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_RST:   state_next = ST_T0;
            ST_T0:    state_next = ST_T1;
            ST_T1:    state_next = ST_T2;
            ST_T2:    state_next = ST_T3;
            ST_T3: begin
                case (iclass)
                    CL_SINGLE, CL_NOP: state_next = boundary;
                    CL_HALT:           state_next = ST_HALT;
                    default:           state_next = ST_T4;
                endcase
            end
            ST_T4: begin
                if (iclass == CL_UNARY) begin
                    state_next = boundary;
                end else if (iclass == CL_MULDIV && is_div && DIV_WAITS) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = CW'(DIV_CYCLES);
                end else begin
                    state_next = ST_T5;
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg - CW'(1);
                if (last_wait) state_next = ST_T5;
            end
            ST_T5: begin
                case (iclass)
                    CL_MULDIV, CL_LD, CL_ST, CL_BR: state_next = ST_T6;
                    default:                        state_next = boundary;
                endcase
            end
            ST_T6: begin
                if (iclass == CL_LD || iclass == CL_ST) state_next = ST_T7;
                else                                    state_next = boundary;
            end
            ST_T7:    state_next = boundary;
            ST_PAUSE: state_next = stop ? ST_PAUSE : ST_T0;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_RST;
        endcase
    end

    // State register; clr low forces RST immediately
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg    <= ST_RST;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Control strobes decoded from the current step and the opcode
    always_comb begin
        run = 1'b0; alu_op = 5'b00000;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0;
        PCout = 1'b0; PCin = 1'b0; incPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        ZLowOut = 1'b0; ZHighOut = 1'b0;
        HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        InPortout = 1'b0; OutPortIn = 1'b0; CONN_in = 1'b0;
        read = 1'b0; write = 1'b0;
        if (state_reg != ST_RST && state_reg != ST_PAUSE && state_reg != ST_HALT) begin
            run    = 1'b1;
            alu_op = OP_ADD;
        end
        case (state_reg)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin ZLowOut = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (iclass)
                    CL_ALU_RR, CL_ALU_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_UNARY: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    CL_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CL_BR: begin Gra = 1'b1; Rout = 1'b1; CONN_in = 1'b1; end
                    CL_SINGLE: begin
                        case (opcode)
                            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
                            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (iclass)
                    CL_ALU_RR:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    CL_ALU_IMM: begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    CL_UNARY:   begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; alu_op = opcode;
                        // A waiting div captures Z at the end of WAIT instead
                        Zin = !(is_div && DIV_WAITS);
                    end
                    CL_LD, CL_LDI, CL_ST: begin Cout = 1'b1; Zin = 1'b1; end
                    CL_BR: begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            ST_WAIT: begin
                Grb = 1'b1; Rout = 1'b1; alu_op = opcode; Zin = last_wait;
            end
            ST_T5: begin
                case (iclass)
                    CL_ALU_RR, CL_ALU_IMM, CL_LDI: begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MULDIV: begin ZLowOut = 1'b1; LOin = 1'b1; end
                    CL_LD, CL_ST: begin ZLowOut = 1'b1; MARin = 1'b1; end
                    CL_BR: begin Cout = 1'b1; Zin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (iclass)
                    CL_MULDIV: begin ZHighOut = 1'b1; HIin = 1'b1; end
                    CL_LD: begin read = 1'b1; MDRin = 1'b1; end
                    CL_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    CL_BR: begin ZLowOut = con_ff; PCin = con_ff; end
                    default: ;
                endcase
            end
            ST_T7: begin
                if (iclass == CL_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (iclass == CL_ST) write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a per-cycle table of expected strobe
// words for each instruction class, plus reset, pause, halt and
// zero-latency div sequences.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr, con_ff, stop;
    logic [31:0] ir;

    // Main instance (DIV_CYCLES=4) outputs
    logic run, Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, incPC, MARin;
    logic MDRin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout;
    logic InPortout, OutPortIn, CONN_in, read, write;
    logic [4:0] alu_op;
    // Zero-wait instance (DIV_CYCLES=0) outputs
    logic z_run, z_Gra, z_Grb, z_Grc, z_Rin, z_Rout, z_BAout, z_Cout, z_PCout, z_PCin;
    logic z_incPC, z_MARin, z_MDRin, z_MDRout, z_IRin, z_Yin, z_Zin, z_ZLowOut, z_ZHighOut;
    logic z_HIin, z_LOin, z_HIout, z_LOout, z_InPortout, z_OutPortIn, z_CONN_in, z_read, z_write;
    logic [4:0] z_alu_op;

    always #5 clk = ~clk;

    control_unit #(.DIV_CYCLES(4)) dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run), .alu_op(alu_op),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
        .OutPortIn(OutPortIn), .CONN_in(CONN_in), .read(read), .write(write)
    );

    control_unit #(.DIV_CYCLES(0)) dut0 (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .run(z_run), .alu_op(z_alu_op),
        .Gra(z_Gra), .Grb(z_Grb), .Grc(z_Grc), .Rin(z_Rin), .Rout(z_Rout), .BAout(z_BAout),
        .Cout(z_Cout), .PCout(z_PCout), .PCin(z_PCin), .incPC(z_incPC), .MARin(z_MARin),
        .MDRin(z_MDRin), .MDRout(z_MDRout), .IRin(z_IRin), .Yin(z_Yin), .Zin(z_Zin),
        .ZLowOut(z_ZLowOut), .ZHighOut(z_ZHighOut), .HIin(z_HIin), .LOin(z_LOin),
        .HIout(z_HIout), .LOout(z_LOout), .InPortout(z_InPortout), .OutPortIn(z_OutPortIn),
        .CONN_in(z_CONN_in), .read(z_read), .write(z_write)
    );

    // Observed word: [32:28] alu_op, [27] run, [26:0] strobes
    logic [32:0] obs, obs0;
    assign obs  = {alu_op, run, write, read, CONN_in, OutPortIn, InPortout, LOout, HIout,
                   LOin, HIin, ZHighOut, ZLowOut, Zin, Yin, IRin, MDRout, MDRin, MARin,
                   incPC, PCin, PCout, Cout, BAout, Rout, Rin, Grc, Grb, Gra};
    assign obs0 = {z_alu_op, z_run, z_write, z_read, z_CONN_in, z_OutPortIn, z_InPortout,
                   z_LOout, z_HIout, z_LOin, z_HIin, z_ZHighOut, z_ZLowOut, z_Zin, z_Yin,
                   z_IRin, z_MDRout, z_MDRin, z_MARin, z_incPC, z_PCin, z_PCout, z_Cout,
                   z_BAout, z_Rout, z_Rin, z_Grc, z_Grb, z_Gra};

    localparam logic [32:0] GRA = 33'd1 << 0,  GRB = 33'd1 << 1,  GRC = 33'd1 << 2;
    localparam logic [32:0] RIN = 33'd1 << 3,  ROUT = 33'd1 << 4, BAOUT = 33'd1 << 5;
    localparam logic [32:0] COUT = 33'd1 << 6, PCOUT = 33'd1 << 7, PCIN = 33'd1 << 8;
    localparam logic [32:0] INCPC = 33'd1 << 9, MARIN = 33'd1 << 10, MDRIN = 33'd1 << 11;
    localparam logic [32:0] MDROUT = 33'd1 << 12, IRIN = 33'd1 << 13, YIN = 33'd1 << 14;
    localparam logic [32:0] ZIN = 33'd1 << 15, ZLOW = 33'd1 << 16, ZHIGH = 33'd1 << 17;
    localparam logic [32:0] HIIN = 33'd1 << 18, LOIN = 33'd1 << 19, HIOUT = 33'd1 << 20;
    localparam logic [32:0] LOOUT = 33'd1 << 21, INPORT = 33'd1 << 22, OUTPORT = 33'd1 << 23;
    localparam logic [32:0] CONN = 33'd1 << 24, READ = 33'd1 << 25, WRITE = 33'd1 << 26;
    localparam logic [32:0] RUN = 33'd1 << 27;
    localparam logic [32:0] FULL = {33{1'b1}};
    localparam logic [32:0] NOALU = ~(33'h1F << 28);

    localparam logic [31:0] I_ADD = 32'h19890000, I_SUB = 32'h20000000, I_ADDI = 32'h58000000;
    localparam logic [31:0] I_NEG = 32'h80000000, I_NOT = 32'h88000000, I_LD = 32'h01000055;
    localparam logic [31:0] I_LDI = 32'h08000000, I_ST = 32'h10000000, I_BR = 32'h91000008;
    localparam logic [31:0] I_MUL = 32'h70000000, I_DIV = 32'h79000000, I_JR = 32'h98000000;
    localparam logic [31:0] I_IN = 32'hA8000000, I_OUT = 32'hB0000000, I_MFHI = 32'hB8000000;
    localparam logic [31:0] I_MFLO = 32'hC0000000, I_NOP = 32'hC8000000, I_UND = 32'hA0000000;
    localparam logic [31:0] I_HALT = 32'hD0000000;

    function automatic logic [32:0] opw(input int op);
        return RUN | (33'(op) << 28);
    endfunction

    logic [32:0] A, F0, F1, F2;

    typedef struct packed {
        logic [31:0] ir;
        logic        con;
        logic [32:0] exp;
    } row_t;
    row_t rows[$];

    int checks = 0;
    int errors = 0;
    int stepn  = 0;

    task automatic push(input logic [31:0] i, input logic c, input logic [32:0] e);
        rows.push_back('{ir: i, con: c, exp: e});
    endtask

    task automatic fetch(input logic [31:0] i, input logic c);
        push(i, c, F0); push(i, c, F1); push(i, c, F2);
    endtask

    task automatic check(input string nm, input logic [32:0] got, input logic [32:0] exp,
                         input logic [32:0] mask);
        checks++;
        if ((got & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s step %0d: got %h required %h", nm, stepn, got & mask, exp & mask);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, then compare
    task automatic step(input logic [31:0] i, input logic c, input logic [32:0] e,
                        input logic [32:0] mask, input bit use0, input string nm);
        @(negedge clk);
        ir = i; con_ff = c; stepn++;
        #1;
        check(nm, use0 ? obs0 : obs, e, mask);
    endtask

    initial begin
        A  = opw(3);
        F0 = A | PCOUT | MARIN | INCPC | ZIN;
        F1 = A | ZLOW | PCIN | READ | MDRIN;
        F2 = A | MDROUT | IRIN;

        fetch(I_ADD, 0); push(I_ADD, 0, A|GRB|ROUT|YIN); push(I_ADD, 0, A|GRC|ROUT|ZIN);
        push(I_ADD, 0, A|ZLOW|GRA|RIN);
        fetch(I_SUB, 0); push(I_SUB, 0, A|GRB|ROUT|YIN); push(I_SUB, 0, opw(4)|GRC|ROUT|ZIN);
        push(I_SUB, 0, A|ZLOW|GRA|RIN);
        fetch(I_ADDI, 0); push(I_ADDI, 0, A|GRB|ROUT|YIN); push(I_ADDI, 0, opw(11)|COUT|ZIN);
        push(I_ADDI, 0, A|ZLOW|GRA|RIN);
        fetch(I_NEG, 0); push(I_NEG, 0, opw(16)|GRB|ROUT|ZIN); push(I_NEG, 0, A|ZLOW|GRA|RIN);
        fetch(I_NOT, 0); push(I_NOT, 0, opw(17)|GRB|ROUT|ZIN); push(I_NOT, 0, A|ZLOW|GRA|RIN);
        fetch(I_LD, 0); push(I_LD, 0, A|GRB|BAOUT|YIN); push(I_LD, 0, A|COUT|ZIN);
        push(I_LD, 0, A|ZLOW|MARIN); push(I_LD, 0, A|READ|MDRIN); push(I_LD, 0, A|MDROUT|GRA|RIN);
        fetch(I_LDI, 0); push(I_LDI, 0, A|GRB|BAOUT|YIN); push(I_LDI, 0, A|COUT|ZIN);
        push(I_LDI, 0, A|ZLOW|GRA|RIN);
        fetch(I_ST, 0); push(I_ST, 0, A|GRB|BAOUT|YIN); push(I_ST, 0, A|COUT|ZIN);
        push(I_ST, 0, A|ZLOW|MARIN); push(I_ST, 0, A|GRA|ROUT|MDRIN); push(I_ST, 0, A|WRITE);
        for (int c = 0; c < 2; c++) begin
            fetch(I_BR, c[0]); push(I_BR, c[0], A|GRA|ROUT|CONN); push(I_BR, c[0], A|PCOUT|YIN);
            push(I_BR, c[0], A|COUT|ZIN); push(I_BR, c[0], c[0] ? (A|ZLOW|PCIN) : A);
        end
        fetch(I_MUL, 0); push(I_MUL, 0, A|GRA|ROUT|YIN); push(I_MUL, 0, opw(14)|GRB|ROUT|ZIN);
        push(I_MUL, 0, A|ZLOW|LOIN); push(I_MUL, 0, A|ZHIGH|HIIN);
        fetch(I_DIV, 0); push(I_DIV, 0, A|GRA|ROUT|YIN);
        for (int w = 0; w < 4; w++) push(I_DIV, 0, opw(15)|GRB|ROUT);
        push(I_DIV, 0, opw(15)|GRB|ROUT|ZIN);
        push(I_DIV, 0, A|ZLOW|LOIN); push(I_DIV, 0, A|ZHIGH|HIIN);
        fetch(I_JR, 0);   push(I_JR, 0, A|GRA|ROUT|PCIN);
        fetch(I_IN, 0);   push(I_IN, 0, A|INPORT|GRA|RIN);
        fetch(I_OUT, 0);  push(I_OUT, 0, A|GRA|ROUT|OUTPORT);
        fetch(I_MFHI, 0); push(I_MFHI, 0, A|HIOUT|GRA|RIN);
        fetch(I_MFLO, 0); push(I_MFLO, 0, A|LOOUT|GRA|RIN);
        fetch(I_NOP, 0);  push(I_NOP, 0, A);
        fetch(I_UND, 0);  push(I_UND, 0, A);

        // Reset state, then clr pulled low for three cycles during T4 of add
        clr = 1'b0; stop = 1'b0; ir = I_ADD; con_ff = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_idle", obs, 33'd0, FULL);
        @(negedge clk); clr = 1'b1;
        step(I_ADD, 0, F0, FULL, 0, "add_pre_T0");
        step(I_ADD, 0, F1, FULL, 0, "add_pre_T1");
        step(I_ADD, 0, F2, FULL, 0, "add_pre_T2");
        step(I_ADD, 0, A|GRB|ROUT|YIN, FULL, 0, "add_pre_T3");
        @(negedge clk); clr = 1'b0; stepn++;
        #1; check("clr_in_T4", obs, 33'd0, FULL);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); stepn++;
            #1; check("clr_held", obs, 33'd0, FULL);
        end
        @(negedge clk); clr = 1'b1;

        // Table: first row checks the T0 that follows reset release
        for (int r = 0; r < rows.size(); r++) begin
            if (rows[r].exp == F0)
                $display("instr ir=%h con_ff=%0d at step %0d", rows[r].ir, rows[r].con, stepn + 1);
            step(rows[r].ir, rows[r].con, rows[r].exp, FULL, 0, "table");
        end

        // stop raised in T1 takes effect only at the instruction boundary
        $display("pause sequence at step %0d", stepn + 1);
        step(I_ADD, 0, F0, FULL, 0, "pause_T0");
        step(I_ADD, 0, F1, FULL, 0, "pause_T1");
        stop = 1'b1;
        step(I_ADD, 0, F2, FULL, 0, "pause_T2");
        step(I_ADD, 0, A|GRB|ROUT|YIN, FULL, 0, "pause_T3");
        step(I_ADD, 0, A|GRC|ROUT|ZIN, FULL, 0, "pause_T4");
        step(I_ADD, 0, A|ZLOW|GRA|RIN, FULL, 0, "pause_T5");
        step(I_ADD, 0, 33'd0, NOALU, 0, "paused");
        step(I_ADD, 0, 33'd0, NOALU, 0, "paused_hold");
        stop = 1'b0;
        step(I_HALT, 0, F0, FULL, 0, "pause_resume");

        // halt parks until clr
        $display("halt sequence at step %0d", stepn);
        step(I_HALT, 0, F1, FULL, 0, "halt_T1");
        step(I_HALT, 0, F2, FULL, 0, "halt_T2");
        step(I_HALT, 0, A, FULL, 0, "halt_T3");
        for (int h = 0; h < 20; h++) begin
            stop = h[2];
            step(I_ADD, 0, 33'd0, NOALU, 0, "halted");
        end
        stop = 1'b0;
        @(negedge clk); clr = 1'b0; stepn++;
        #1; check("halt_clr", obs, 33'd0, FULL);
        @(negedge clk); clr = 1'b1;
        step(I_DIV, 0, F0, FULL, 0, "halt_recover");

        // Zero-wait div follows mul timing
        $display("div with DIV_CYCLES=0 at step %0d", stepn);
        step(I_DIV, 0, F1, FULL, 1, "div0_T1");
        step(I_DIV, 0, F2, FULL, 1, "div0_T2");
        step(I_DIV, 0, A|GRA|ROUT|YIN, FULL, 1, "div0_T3");
        step(I_DIV, 0, opw(15)|GRB|ROUT|ZIN, FULL, 1, "div0_T4");
        step(I_DIV, 0, A|ZLOW|LOIN, FULL, 1, "div0_T5");
        step(I_DIV, 0, A|ZHIGH|HIIN, FULL, 1, "div0_T6");
        step(I_NOP, 0, F0, FULL, 1, "div0_next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
